// File: rtl/network_conv_acc_requant.sv
// rtl/network_conv_acc_requant.sv - conv product accumulator with bias seed, round/shift requant and saturation
// Optional feature macro: NETWORK_CONV_ACC_RELU_EN (fused ReLU after saturation)
module network_conv_acc_requant #(
  parameter int PROD_WIDTH = 28,
  parameter int ACC_WIDTH  = 36,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            cfg_taps,
  input  logic [OUT_WIDTH-1:0]  bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  // One extra bit so adding the rounding constant can never wrap the sum.
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [RW-1:0]        RND_HALF = RW'(1) << (FRAC_SHIFT - 1);

  state_t                 state, state_next;
  logic signed [ACC_WIDTH-1:0] acc, acc_next;
  logic [7:0]             tap_cnt, tap_cnt_next;
  logic [7:0]             taps_q, taps_next;
  logic                   accept;
  logic                   last;
  logic [ACC_WIDTH-1:0]   bias_ext;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic signed [RW-1:0]   rnd_sum;
  logic signed [RW-1:0]   rnd_shift;
  logic [OUT_WIDTH-1:0]   sat_val;
  logic [OUT_WIDTH-1:0]   req_val;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign bias_ext  = {{(ACC_WIDTH-OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias} << FRAC_SHIFT;
  assign prod_ext  = {{(ACC_WIDTH-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};

  // Stream handshake: products are refused only while a result is pending.
  always_comb begin
    in_ready = (state != S_DONE);
  end

  // Window sequencing and running sum for the product being accepted this cycle.
  always_comb begin
    state_next   = state;
    acc_next     = acc;
    tap_cnt_next = tap_cnt;
    taps_next    = taps_q;
    last         = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          taps_next    = (cfg_taps == 8'd0) ? 8'd1 : cfg_taps;
          acc_next     = $signed(bias_ext + prod_ext);
          tap_cnt_next = 8'd1;
          last         = (taps_next == 8'd1);
          state_next   = last ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_next     = $signed(acc + prod_ext);
          tap_cnt_next = tap_cnt + 8'd1;
          last         = (tap_cnt_next == taps_q);
          state_next   = last ? S_DONE : S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Round half up, arithmetic shift to output scale, then clamp to the output range.
  always_comb begin
    rnd_sum   = $signed({acc_next[ACC_WIDTH-1], acc_next} + RND_HALF);
    rnd_shift = rnd_sum >>> FRAC_SHIFT;
    if (rnd_shift > SAT_MAX)      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (rnd_shift < SAT_MIN) sat_val = SAT_MIN[OUT_WIDTH-1:0];
    else                          sat_val = rnd_shift[OUT_WIDTH-1:0];
`ifdef NETWORK_CONV_ACC_RELU_EN
    req_val = sat_val[OUT_WIDTH-1] ? '0 : sat_val;
`else
    req_val = sat_val;
`endif
  end

  // State, accumulator and result registers; result captured with the last product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      tap_cnt  <= '0;
      taps_q   <= 8'd1;
      out_data <= '0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      tap_cnt <= tap_cnt_next;
      taps_q  <= taps_next;
      if (last) out_data <= req_val;
    end
  end

endmodule

// File: tb/tb_network_conv_acc_requant.sv
// tb/tb_network_conv_acc_requant.sv - directed scoreboard bench for network_conv_acc_requant
module tb_network_conv_acc_requant;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [7:0]         cfg_taps = 8'd0;
  logic signed [15:0] bias = 16'sd0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [27:0] in_prod = 28'sd0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;

  int checks = 0;
  int passed = 0;
  logic signed [15:0] exp_q[$];
  logic signed [27:0] prod_q[$];

  network_conv_acc_requant dut (
    .clk(clk), .reset_n(reset_n), .cfg_taps(cfg_taps), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic int relu(input int v);
`ifdef NETWORK_CONV_ACC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Drive every product queued in prod_q as one window; cfg/bias scrambled after the first.
  task automatic send_window(input string tag, input logic [7:0] taps, input logic signed [15:0] b,
                             input int expected, input bit gaps);
    bit first;
    exp_q.push_back(16'(expected));
    first = 1'b1;
    while (prod_q.size() > 0) begin
      if (first) begin
        cfg_taps = taps;
        bias     = b;
        check({tag, "_in_ready"}, 32'(in_ready), 1);
      end
      in_valid = 1'b1;
      in_prod  = prod_q.pop_front();
      @(negedge clk);
      first    = 1'b0;
      cfg_taps = 8'($urandom);
      bias     = 16'($urandom);
      if (gaps && prod_q.size() > 0) begin
        in_valid = 1'b0;
        in_prod  = 28'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_prod  = 28'($urandom);
    check({tag, "_latency"}, 32'(out_valid), 1);
  endtask

  // Wait (bounded) for a result, compare against the scoreboard, then accept it.
  task automatic collect(input string tag);
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, 32'(out_valid), 1);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else check({tag, "_data"}, out_data, exp_q.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(out_valid), 0);
    check({tag, "_rel_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0;

    // basic 3-tap window
    prod_q = '{28'sd1024, 28'sd2048, -28'sd1024};
    send_window("t1", 8'd3, 16'sd0, 2, 1'b0);
    collect("t1");

    // rounding at the half-LSB boundary
    prod_q = '{28'sd512};  send_window("t2a", 8'd1, 16'sd0, 1, 1'b0);  collect("t2a");
    prod_q = '{28'sd511};  send_window("t2b", 8'd1, 16'sd0, 0, 1'b0);  collect("t2b");
    prod_q = '{-28'sd512}; send_window("t2c", 8'd1, 16'sd0, 0, 1'b0);  collect("t2c");
    prod_q = '{-28'sd513}; send_window("t2d", 8'd1, 16'sd0, relu(-1), 1'b0); collect("t2d");

    // saturation on full 255-tap windows, one with input gaps
    repeat (255) prod_q.push_back(28'sh7FFFFFF);
    send_window("t3p", 8'd255, 16'sd0, 32767, 1'b1);
    collect("t3p");
    repeat (255) prod_q.push_back(-28'sh8000000);
    send_window("t3n", 8'd255, 16'sd0, relu(-32768), 1'b0);
    collect("t3n");

    // bias seeding and taps=0 treated as one tap
    prod_q = '{28'sd0, 28'sd0};
    send_window("t4a", 8'd2, 16'sd5, 5, 1'b1);
    collect("t4a");
    prod_q = '{28'sd1024};
    send_window("t4b", 8'd0, 16'sd5, 6, 1'b0);
    collect("t4b");

    // backpressure: result held, products refused
    prod_q = '{28'sd0};
    send_window("t5", 8'd1, 16'sd7, 7, 1'b0);
    in_valid = 1'b1;
    in_prod  = 28'sd99999;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_data", out_data, 7);
      check("t5_hold_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    collect("t5");

    // reset mid-window discards the partial sum
    cfg_taps = 8'd4;
    bias     = 16'sd100;
    in_valid = 1'b1;
    in_prod  = 28'sd50000;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    prod_q = '{28'sd2048};
    send_window("t6a", 8'd1, 16'sd0, 2, 1'b0);
    collect("t6a");

    // reset while a result is pending drops it
    prod_q = '{28'sd4096};
    send_window("t6d", 8'd1, 16'sd0, 4, 1'b0);
    void'(exp_q.pop_back());
    reset_n = 1'b0;
    #1;
    check("t6d_rst_valid", 32'(out_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6d_no_output", 32'(out_valid), 0);

    // negative result: passes through, or clamps with fused ReLU
    prod_q = '{-28'sd5120};
    send_window("t6r", 8'd1, 16'sd0, relu(-5), 1'b0);
    collect("t6r");

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
